// File: rtl/el_pkg.sv
// Shared types and dual-rail helpers for the asynchronous adder sequencer.
// Rail encoding per bit: 01 = zero, 10 = one, 00 = spacer, 11 = illegal.
package el_pkg;

  typedef enum logic [2:0] {INIT, IDLE, DATA, NULLPH, ERR} state_t;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

  function automatic logic dr_decode(input logic [1:0] p);
    return (p == DR_ONE);
  endfunction

  function automatic logic dr_is_null(input logic [1:0] p);
    return (p == DR_NULL);
  endfunction

  function automatic logic dr_is_valid(input logic [1:0] p);
    return (p == DR_ZERO) || (p == DR_ONE);
  endfunction

endpackage

// File: rtl/el_sync_bus.sv
// Per-bit multi-flop synchroniser for an N-bit bus of asynchronous wires.
// Latency STAGES cycles; no backpressure, the bus is sampled every cycle.
module el_sync_bus #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] sync_q [STAGES];
  logic [N-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/el_adder_ctrl.sv
// Clocked sequencer for a dual-rail four-phase ripple adder: encodes, runs DATA/NULL phases, returns binary result.
// Accept-to-response at least SYNC_STAGES+2 cycles; req_ready only in IDLE, response held until rsp_ready.
module el_adder_ctrl
  import el_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int RAIL_NUM    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic                 rsp_cout,
  output logic                 err,
  output logic                 el_rst,
  output logic [2*WIDTH-1:0]   el_in_a,
  output logic [2*WIDTH-1:0]   el_in_b,
  output logic [1:0]           el_in_c,
  input  logic [WIDTH-1:0]     el_ack_a,
  input  logic [WIDTH-1:0]     el_ack_b,
  input  logic                 el_ack_c,
  input  logic [2*WIDTH-1:0]   el_out_s,
  input  logic [1:0]           el_out_c,
  output logic [WIDTH-1:0]     el_ack_s,
  output logic                 el_ack_c_o
);

  if (RAIL_NUM != 2) begin : g_rail_chk
    $error("el_adder_ctrl: RAIL_NUM must be 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("el_adder_ctrl: SYNC_STAGES must be at least 2");
  end

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int AW = 2*WIDTH + 1;
  localparam int OW = 2*WIDTH + 2;

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_ni;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_ni = rst_sync_q[1];

  logic [AW-1:0] ack_sync;
  logic [OW-1:0] out_sync;

  el_sync_bus #(.N(AW), .STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_ni),
    .d     ({el_ack_c, el_ack_b, el_ack_a}),
    .q     (ack_sync)
  );

  el_sync_bus #(.N(OW), .STAGES(SYNC_STAGES)) u_sync_out (
    .clk   (clk),
    .rst_n (rst_ni),
    .d     ({el_out_c, el_out_s}),
    .q     (out_sync)
  );

  logic               outs_valid, outs_ill, data_done, null_done;
  logic [WIDTH-1:0]   sum_bin;
  logic               cout_bin;
  logic [2*WIDTH-1:0] enc_a, enc_b;

  always_comb begin
    outs_valid = 1'b1;
    outs_ill   = 1'b0;
    sum_bin    = '0;
    enc_a      = '0;
    enc_b      = '0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      outs_valid = outs_valid & ~dr_is_null(out_sync[2*i +: 2]);
      outs_ill   = outs_ill | (out_sync[2*i +: 2] == DR_ILL);
    end
    for (int i = 0; i < WIDTH; i++) begin
      sum_bin[i]       = dr_decode(out_sync[2*i +: 2]);
      enc_a[2*i +: 2]  = dr_encode(req_a[i]);
      enc_b[2*i +: 2]  = dr_encode(req_b[i]);
    end
    cout_bin  = dr_decode(out_sync[2*WIDTH +: 2]);
    data_done = outs_valid & (&ack_sync);
    null_done = ~(|out_sync) & ~(|ack_sync);
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      init_cnt_q, init_cnt_d;
  logic [2*WIDTH-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
  logic [1:0]         in_c_q, in_c_d;
  logic               ack_out_q, ack_out_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               err_q, err_d;
  logic               el_rst_q, el_rst_d;
  logic               null_seen_q, null_seen_d;
  logic               timeout_hit, accept, seen;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign accept      = rsp_valid_q & rsp_ready;
  assign seen        = null_seen_q | null_done;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    in_c_d      = in_c_q;
    ack_out_d   = ack_out_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    err_d       = err_q;
    el_rst_d    = el_rst_q;
    null_seen_d = null_seen_q;

    unique case (state_q)
      INIT: begin
        if (init_cnt_q != IW'(INIT_CYCLES)) begin
          init_cnt_d = init_cnt_q + 1'b1;
          el_rst_d   = (init_cnt_d != IW'(INIT_CYCLES));
        end else if (null_done) begin
          state_d = IDLE;
        end
        if (state_d == INIT && timeout_hit) state_d = ERR;
      end
      IDLE: begin
        if (req_valid) begin
          in_a_d  = enc_a;
          in_b_d  = enc_b;
          in_c_d  = dr_encode(req_cin);
          state_d = DATA;
        end
      end
      DATA: begin
        if (outs_ill) begin
          state_d = ERR;
        end else if (data_done) begin
          rsp_sum_d   = sum_bin;
          rsp_cout_d  = cout_bin;
          rsp_valid_d = 1'b1;
          in_a_d      = '0;
          in_b_d      = '0;
          in_c_d      = DR_NULL;
          ack_out_d   = 1'b1;
          null_seen_d = 1'b0;
          state_d     = NULLPH;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      NULLPH: begin
        if (accept) rsp_valid_d = 1'b0;
        // Acks drop as soon as the spacer is seen, even with the response still pending.
        if (null_done) begin
          ack_out_d   = 1'b0;
          null_seen_d = 1'b1;
        end
        if (outs_ill) begin
          state_d = ERR;
        end else if (seen && (accept || !rsp_valid_q)) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: state_d = ERR;
    endcase

    if (state_d == ERR) begin
      err_d       = 1'b1;
      el_rst_d    = 1'b1;
      in_a_d      = '0;
      in_b_d      = '0;
      in_c_d      = DR_NULL;
      ack_out_d   = 1'b0;
      rsp_valid_d = 1'b0;
    end

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_cnt_q  <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      in_c_q      <= DR_NULL;
      ack_out_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      err_q       <= 1'b0;
      el_rst_q    <= 1'b1;
      null_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_cnt_q  <= init_cnt_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      in_c_q      <= in_c_d;
      ack_out_q   <= ack_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      err_q       <= err_d;
      el_rst_q    <= el_rst_d;
      null_seen_q <= null_seen_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign err        = err_q;
  assign el_rst     = el_rst_q;
  assign el_in_a    = in_a_q;
  assign el_in_b    = in_b_q;
  assign el_in_c    = in_c_q;
  assign el_ack_s   = {WIDTH{ack_out_q}};
  assign el_ack_c_o = ack_out_q;

endmodule

// File: tb/tb_el_adder_ctrl.sv
// Bench for el_adder_ctrl (WIDTH=8) driving a behavioural dual-rail ripple adder with random per-bit delays;
// results are checked against plain binary arithmetic.
module tb_el_adder_ctrl;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [W-1:0]  req_a = '0, req_b = '0;
  logic          req_cin = 1'b0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout, err, el_rst;
  logic [2*W-1:0] el_in_a, el_in_b;
  logic [1:0]    el_in_c;
  logic [W-1:0]  el_ack_a = '0, el_ack_b = '0;
  logic          el_ack_c = 1'b0;
  logic [2*W-1:0] el_out_s = '0;
  logic [1:0]    el_out_c = '0;
  logic [W-1:0]  el_ack_s;
  logic          el_ack_c_o;

  int tests_run = 0;
  int tests_failed = 0;
  int max_dly = 20;
  bit stall = 1'b0;

  always #5 clk = ~clk;

  el_adder_ctrl #(.WIDTH(W), .RAIL_NUM(2), .SYNC_STAGES(SS), .INIT_CYCLES(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .err(err),
    .el_rst(el_rst), .el_in_a(el_in_a), .el_in_b(el_in_b), .el_in_c(el_in_c),
    .el_ack_a(el_ack_a), .el_ack_b(el_ack_b), .el_ack_c(el_ack_c),
    .el_out_s(el_out_s), .el_out_c(el_out_c), .el_ack_s(el_ack_s), .el_ack_c_o(el_ack_c_o)
  );

  function automatic logic [15:0] dr_enc8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] enc1(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  function automatic logic nn(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic logic [1:0] ackdes(input logic [1:0] p, input logic [1:0] cur);
    return nn(p) ? 2'b01 : ((p == 2'b00) ? 2'b00 : cur);
  endfunction

  // Adder environment: every rail/ack moves toward its target after 0..max_dly cycles.
  logic [1:0] m_aa [8], m_ab [8], m_s [8], m_cr [9];
  logic [1:0] m_ac = '0, m_co = '0;
  int d_aa [8], d_ab [8], d_s [8], d_cr [9];
  int d_ac = 0, d_co = 0;

  task automatic step(inout logic [1:0] cur, input logic [1:0] des, inout int d);
    if (cur == des) d = $urandom_range(0, max_dly);
    else if (d <= 0) begin cur = des; d = $urandom_range(0, max_dly); end
    else d--;
  endtask

  always @(negedge clk) begin : model
    logic [1:0] ai, bi, ci;
    if (el_rst) begin
      for (int i = 0; i < 8; i++) begin m_aa[i] = '0; m_ab[i] = '0; m_s[i] = '0; end
      for (int i = 0; i < 9; i++) m_cr[i] = '0;
      m_ac = '0;
      m_co = '0;
    end else begin
      step(m_ac, ackdes(el_in_c, m_ac), d_ac);
      m_cr[0] = el_in_c;
      for (int i = 0; i < 8; i++) begin
        ai = el_in_a[2*i +: 2];
        bi = el_in_b[2*i +: 2];
        ci = m_cr[i];
        step(m_aa[i], ackdes(ai, m_aa[i]), d_aa[i]);
        step(m_ab[i], ackdes(bi, m_ab[i]), d_ab[i]);
        if (nn(ai) && nn(bi) && nn(ci)) begin
          step(m_cr[i+1], enc1((ai[1] & bi[1]) | (ai[1] & ci[1]) | (bi[1] & ci[1])), d_cr[i+1]);
          if (!el_ack_s[i] && !(stall && i == 3)) step(m_s[i], enc1(ai[1] ^ bi[1] ^ ci[1]), d_s[i]);
        end else if (ai == 2'b00 && bi == 2'b00 && ci == 2'b00) begin
          step(m_cr[i+1], 2'b00, d_cr[i+1]);
          if (el_ack_s[i]) step(m_s[i], 2'b00, d_s[i]);
        end
      end
      ci = m_cr[8];
      if (nn(ci) && !el_ack_c_o) step(m_co, ci, d_co);
      else if (ci == 2'b00 && el_ack_c_o) step(m_co, 2'b00, d_co);
    end
    for (int i = 0; i < 8; i++) begin
      el_out_s[2*i +: 2] = m_s[i];
      el_ack_a[i] = m_aa[i][0];
      el_ack_b[i] = m_ab[i][0];
    end
    el_ack_c = m_ac[0];
    el_out_c = m_co;
  end

  task automatic apply_reset(output bit ok);
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    ok = req_ready;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic co, output int lat, output bit tout,
                        output logic [15:0] ina_data, output logic [15:0] ina_after, output bit carry_ok);
    int n;
    tout = 0; carry_ok = 0; s = '0; co = 0; ina_data = '0; ina_after = '0; lat = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) begin tout = 1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    ina_data = el_in_a;
    lat = 1;
    while (!rsp_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin tout = 1; return; end
    s = rsp_sum; co = rsp_cout; ina_after = el_in_a;
    carry_ok = (el_out_c != 2'b00);
    for (int i = 0; i < 8; i++) if (el_out_s[2*i +: 2] == 2'b00) carry_ok = 0;
    n = 0;
    while (!req_ready && n < 3000) begin @(posedge clk); #1; n++; end
    if (!req_ready) tout = 1;
  endtask

  task automatic test_reset;
    bit hold_bad, null_bad;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({el_rst, req_ready, rsp_valid, err} !== 4'b1000) begin
      tests_failed++; $display("FAIL reset_ctl: got %b expected 1000", {el_rst, req_ready, rsp_valid, err});
    end
    tests_run++;
    if ({el_in_a, el_in_b, el_in_c, el_ack_s, el_ack_c_o} !== '0) begin
      tests_failed++; $display("FAIL reset_rails: got %h expected 0", {el_in_a, el_in_b, el_in_c, el_ack_s, el_ack_c_o});
    end
    tests_run++;
    if ({rsp_sum, rsp_cout} !== '0) begin
      tests_failed++; $display("FAIL reset_rsp: got %h expected 0", {rsp_sum, rsp_cout});
    end
    rst_n = 1'b1;
    hold_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (el_rst !== 1'b1 || req_ready !== 1'b0) hold_bad = 1;
    end
    tests_run++;
    if (hold_bad) begin tests_failed++; $display("FAIL el_rst_hold: got 1 expected 0 (el_rst low or ready early)"); end
    null_bad = 0; n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      if ({el_in_a, el_in_b, el_in_c} !== '0 || rsp_valid !== 1'b0) null_bad = 1;
      n++;
    end
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_init: got %b expected 1", req_ready); end
    tests_run++;
    if (el_rst !== 1'b0) begin tests_failed++; $display("FAIL el_rst_release: got %b expected 0", el_rst); end
    tests_run++;
    if (null_bad) begin tests_failed++; $display("FAIL init_null: got 1 expected 0"); end
  endtask

  task automatic test_basic_add;
    logic [7:0] s; logic co; int lat; bit tout, cok; logic [15:0] ind, ina;
    logic [8:0] exp;
    max_dly = 0;
    exp = 9'(8'h5A) + 9'(8'h33);
    run_op(8'h5A, 8'h33, 1'b0, s, co, lat, tout, ind, ina, cok);
    tests_run++;
    if (tout || {co, s} !== exp) begin tests_failed++; $display("FAIL basic_sum: got %h expected %h (tout=%0d)", {co, s}, exp, tout); end
    tests_run++;
    if (lat != SS + 2) begin tests_failed++; $display("FAIL basic_latency: got %0d expected %0d", lat, SS + 2); end
    tests_run++;
    if (ind !== dr_enc8(8'h5A)) begin tests_failed++; $display("FAIL basic_in_a_data: got %h expected %h", ind, dr_enc8(8'h5A)); end
    tests_run++;
    if (ina !== 16'h0) begin tests_failed++; $display("FAIL basic_in_a_null: got %h expected 0", ina); end
    max_dly = 20;
  endtask

  task automatic test_carry_ripple;
    logic [7:0] s; logic co; int lat; bit tout, cok; logic [15:0] ind, ina;
    run_op(8'hFF, 8'h00, 1'b1, s, co, lat, tout, ind, ina, cok);
    tests_run++;
    if (tout || s !== 8'h00 || co !== 1'b1) begin tests_failed++; $display("FAIL ripple_sum: got %h expected 100", {co, s}); end
    tests_run++;
    if (!cok) begin tests_failed++; $display("FAIL ripple_early_rsp: got 0 expected 1 (carry resolved)"); end
  endtask

  task automatic test_random;
    logic [7:0] a, b, s; logic cin, co; int lat; bit tout, cok; logic [15:0] ind, ina;
    logic [8:0] exp;
    for (int k = 0; k < 16; k++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(cin);
      run_op(a, b, cin, s, co, lat, tout, ind, ina, cok);
      tests_run++;
      if (tout || {co, s} !== exp) begin
        tests_failed++; $display("FAIL rand_sum[%0d]: got %h expected %h (tout=%0d)", k, {co, s}, exp, tout);
      end
      tests_run++;
      if (lat < SS + 2 || !cok) begin
        tests_failed++; $display("FAIL rand_timing[%0d]: got lat %0d resolved %0d expected lat>=%0d resolved 1", k, lat, cok, SS + 2);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] a, b, s0; logic [8:0] exp; int n, k; bit unstable, dropped, early;
    max_dly = 2;
    a = 8'($urandom); b = 8'($urandom);
    exp = 9'(a) + 9'(b);
    @(negedge clk);
    req_a = a; req_b = b; req_cin = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    s0 = rsp_sum;
    tests_run++;
    if (rsp_valid !== 1'b1 || {rsp_cout, s0} !== exp) begin
      tests_failed++; $display("FAIL bp_sum: got %h valid %b expected %h", {rsp_cout, s0}, rsp_valid, exp);
    end
    tests_run++;
    if (el_ack_s !== 8'hFF || el_ack_c_o !== 1'b1) begin
      tests_failed++; $display("FAIL bp_ack_raise: got %h expected 1ff", {el_ack_c_o, el_ack_s});
    end
    unstable = 0; dropped = 0; early = 0; k = 0;
    while ((k < 50 || !dropped) && k < 600) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_sum !== s0 || req_ready !== 1'b0) unstable = 1;
      if (!dropped && el_ack_s == 8'h00) begin
        dropped = 1;
        if (el_out_s !== '0 || el_out_c !== 2'b00) early = 1;
      end
      k++;
    end
    tests_run++;
    if (unstable) begin tests_failed++; $display("FAIL bp_hold: got 1 expected 0 (response changed or ready high)"); end
    tests_run++;
    if (!dropped || early) begin tests_failed++; $display("FAIL bp_ack_drop: got dropped %0d early %0d expected 1 0", dropped, early); end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_idle_after_accept: got ready %b valid %b expected 1 0", req_ready, rsp_valid);
    end
    max_dly = 20;
  endtask

  task automatic test_timeout;
    int n, lat; bit saw_rsp, left_err, ok;
    stall = 1'b1;
    @(negedge clk);
    req_a = 8'hA5; req_b = 8'h3C; req_cin = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; saw_rsp = 0;
    while (!err && lat < 1200) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid) saw_rsp = 1;
    end
    tests_run++;
    if (err !== 1'b1 || lat < TO || lat > TO + 2 || saw_rsp) begin
      tests_failed++; $display("FAIL timeout_err: got err %b after %0d cycles rsp %0d expected err 1 after %0d..%0d", err, lat, saw_rsp, TO, TO + 2);
    end
    tests_run++;
    if (el_rst !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || {el_in_a, el_in_b, el_in_c, el_ack_s} !== '0) begin
      tests_failed++; $display("FAIL timeout_outputs: got rst %b ready %b valid %b rails %h expected 1 0 0 0", el_rst, req_ready, rsp_valid, {el_in_a, el_in_b, el_in_c});
    end
    stall = 1'b0;
    left_err = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (err !== 1'b1 || req_ready !== 1'b0 || el_rst !== 1'b1) left_err = 1;
    end
    tests_run++;
    if (left_err) begin tests_failed++; $display("FAIL timeout_sticky: got 1 expected 0 (left error state)"); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL timeout_clear: got %b expected 0", err); end
    apply_reset(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL timeout_recover: got ready 0 expected 1"); end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] s; logic co; int n, lat; bit tout, cok, ok; logic [15:0] ind, ina;
    @(negedge clk);
    req_a = 8'h3C; req_b = 8'h41; req_cin = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (el_in_a !== dr_enc8(8'h3C)) begin tests_failed++; $display("FAIL midrst_data: got %h expected %h", el_in_a, dr_enc8(8'h3C)); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({el_in_a, el_in_b, el_in_c} !== '0 || rsp_valid !== 1'b0 || err !== 1'b0 || el_rst !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_null: got rails %h valid %b err %b rst %b expected 0 0 0 1", {el_in_a, el_in_b, el_in_c}, rsp_valid, err, el_rst);
    end
    apply_reset(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL midrst_recover: got ready 0 expected 1"); end
    run_op(8'h01, 8'h01, 1'b0, s, co, lat, tout, ind, ina, cok);
    tests_run++;
    if (tout || s !== 8'h02 || co !== 1'b0) begin tests_failed++; $display("FAIL midrst_sum: got %h expected 002", {co, s}); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
